wb_spram_front: RTL and testbench



---
 rtl/wb_spram_pkg.sv | 22 ++
 rtl/wb_spram_front_resp_pipe.sv | 49 ++++
 rtl/wb_spram_front.sv | 164 ++++++++++++++++
 tb/tb_wb_spram_front.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spram_pkg.sv
// Shared types and constants for the Wishbone single-port RAM front-end.
package wb_spram_pkg;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  // One slot of the response alignment pipeline.
  typedef struct packed {
    logic valid;
    logic err;
  } resp_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fsm_state_e;

  function automatic logic legal_read_latency(input int rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction

endpackage

// File: rtl/wb_spram_front_resp_pipe.sv
// Shift register of response slots with a synchronous flush of all valid bits.
module resp_pipe
  import wb_spram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push_valid,
  input  logic push_err,
  output logic out_valid,
  output logic out_err,
  output logic tap_valid
);

  resp_t [DEPTH-1:0] stage_q;
  resp_t [DEPTH-1:0] stage_d;

  // advance every slot one step; a flush kills all requests in flight
  always_comb begin
    stage_d          = stage_q;
    stage_d[0].valid = push_valid;
    stage_d[0].err   = push_err;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i].valid = stage_d[i].valid & ~flush;
    end
  end

  // pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // last slot terminates the bus cycle; the one before it times the data capture
  always_comb begin
    out_valid = stage_q[DEPTH-1].valid;
    out_err   = stage_q[DEPTH-1].err;
    tap_valid = stage_q[DEPTH-2].valid;
  end

endmodule

// File: rtl/wb_spram_front.sv
// Wishbone B4 pipelined slave driving a byte-write, write-first block RAM,
// with optional zero-fill after reset and latency-aligned ack/err.
module wb_spram_front
  import wb_spram_pkg::*;
#(
  parameter int NB_COL         = 4,
  parameter int COL_WIDTH      = 8,
  parameter int RAM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1,
  parameter int BUS_AW         = 28
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [BUS_AW-1:0]               wb_adr,
  input  logic [NB_COL*COL_WIDTH-1:0]     wb_dat_w,
  input  logic [NB_COL-1:0]               wb_sel,
  input  logic                            wb_we,
  input  logic                            wb_cyc,
  input  logic                            wb_stb,
  output logic                            wb_stall,
  output logic                            wb_ack,
  output logic                            wb_err,
  output logic [NB_COL*COL_WIDTH-1:0]     wb_dat_r,
  output logic [$clog2(RAM_DEPTH)-1:0]    ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]     ram_din,
  output logic [NB_COL-1:0]               ram_we,
  input  logic [NB_COL*COL_WIDTH-1:0]     ram_dout
);

  localparam int                AW        = $clog2(RAM_DEPTH);
  localparam int                DW        = NB_COL * COL_WIDTH;
  localparam int                PD        = READ_LATENCY + 1;
  localparam logic [BUS_AW-1:0] DEPTH_BUS = BUS_AW'(RAM_DEPTH);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam fsm_state_e        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  if (!legal_read_latency(READ_LATENCY)) begin : g_bad_latency
    $error("wb_spram_front: READ_LATENCY must be 1 or 2");
  end
  if (COL_WIDTH != 8) begin : g_bad_col_width
    $error("wb_spram_front: COL_WIDTH must be 8 for Wishbone byte lanes");
  end

  fsm_state_e               state_q, state_d;
  logic [AW-1:0]            clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [DW-1:0]            din_q, din_d;
  logic [DW-1:0]            dat_r_q, dat_r_d;
  logic [READ_LATENCY-1:0]  rd_q, rd_d;
  logic                     accept_s;
  logic                     in_range_s;
  logic                     pipe_valid_s;
  logic                     pipe_err_s;
  logic                     pipe_tap_s;

  // zero-fill sequencing: walk every address once, then serve the bus forever
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // stall while clearing; during reset report the post-reset value
  always_comb begin
    if (!rst_n) begin
      wb_stall = (CLEAR_ON_RESET != 0);
    end else begin
      wb_stall = (state_q == ST_CLEAR);
    end
  end

  // request acceptance and address range check
  always_comb begin
    accept_s   = rst_n & wb_cyc & wb_stb & ~wb_stall;
    in_range_s = (wb_adr < DEPTH_BUS);
  end

  // RAM port drive: clear pattern, live bus request, or hold when idle
  always_comb begin
    ram_addr = addr_q;
    ram_din  = din_q;
    ram_we   = '0;
    if (!rst_n) begin
      ram_addr = '0;
      ram_din  = '0;
    end else if (state_q == ST_CLEAR) begin
      ram_addr = clr_cnt_q;
      ram_din  = '0;
      ram_we   = '1;
    end else if (accept_s) begin
      ram_addr = wb_adr[AW-1:0];
      ram_din  = wb_dat_w;
      ram_we   = (wb_we && in_range_s) ? wb_sel : NB_COL'(0);
    end else begin
      ram_we   = '0;
    end
  end

  // remember what was last driven so the RAM port does not toggle when idle;
  // read flags ride alongside the response pipe up to the capture slot
  always_comb begin
    addr_d   = ram_addr;
    din_d    = ram_din;
    rd_d     = rd_q << 1'b1;
    rd_d[0]  = accept_s & ~wb_we & in_range_s;
    if (wb_cyc && pipe_tap_s && rd_q[READ_LATENCY-1]) begin
      dat_r_d = ram_dout;
    end else begin
      dat_r_d = '0;
    end
  end

  // control and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      dat_r_q   <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      dat_r_q   <= dat_r_d;
      rd_q      <= rd_d;
    end
  end

  resp_pipe #(
    .DEPTH(PD)
  ) u_resp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (~wb_cyc),
    .push_valid (accept_s),
    .push_err   (~in_range_s),
    .out_valid  (pipe_valid_s),
    .out_err    (pipe_err_s),
    .tap_valid  (pipe_tap_s)
  );

  // terminations come straight from the last pipeline slot, never both at once
  always_comb begin
    wb_ack   = pipe_valid_s & ~pipe_err_s;
    wb_err   = pipe_valid_s & pipe_err_s;
    wb_dat_r = dat_r_q;
  end

endmodule

// File: tb/tb_wb_spram_front.sv
// Self-checking bench: table vectors, directed corner sequences and random
// traffic against a word-level memory/response model.
module tb_wb_spram_front;

  localparam int DEPTH_A = 1024;
  localparam int RL_A    = 2;
  localparam int DEPTH_B = 16;
  localparam int RL_B    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // instance A: default parameters
  logic        a_rst_n, a_we, a_cyc, a_stb, a_stall, a_ack, a_err;
  logic [27:0] a_adr;
  logic [31:0] a_dat_w, a_dat_r, a_ram_din, a_ram_dout;
  logic [3:0]  a_sel, a_ram_we;
  logic [9:0]  a_ram_addr;

  // instance B: low-latency RAM, small depth
  logic        b_rst_n, b_we, b_cyc, b_stb, b_stall, b_ack, b_err;
  logic [27:0] b_adr;
  logic [31:0] b_dat_w, b_dat_r, b_ram_din, b_ram_dout;
  logic [3:0]  b_sel, b_ram_we;
  logic [3:0]  b_ram_addr;

  wb_spram_front dut_a (
    .clk(clk), .rst_n(a_rst_n), .wb_adr(a_adr), .wb_dat_w(a_dat_w), .wb_sel(a_sel),
    .wb_we(a_we), .wb_cyc(a_cyc), .wb_stb(a_stb), .wb_stall(a_stall), .wb_ack(a_ack),
    .wb_err(a_err), .wb_dat_r(a_dat_r), .ram_addr(a_ram_addr), .ram_din(a_ram_din),
    .ram_we(a_ram_we), .ram_dout(a_ram_dout)
  );

  wb_spram_front #(.RAM_DEPTH(DEPTH_B), .READ_LATENCY(RL_B)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .wb_adr(b_adr), .wb_dat_w(b_dat_w), .wb_sel(b_sel),
    .wb_we(b_we), .wb_cyc(b_cyc), .wb_stb(b_stb), .wb_stall(b_stall), .wb_ack(b_ack),
    .wb_err(b_err), .wb_dat_r(b_dat_r), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
    .ram_we(b_ram_we), .ram_dout(b_ram_dout)
  );

  // write-first byte-write RAM models (A: output-registered, B: low latency)
  logic [31:0] mem_a [DEPTH_A];
  logic [31:0] mem_b [DEPTH_B];
  logic [31:0] a_wr_word, b_wr_word, a_rd1;

  always_comb begin
    a_wr_word = mem_a[a_ram_addr];
    b_wr_word = mem_b[b_ram_addr];
    for (int c = 0; c < 4; c++) begin
      if (a_ram_we[c]) a_wr_word[c*8 +: 8] = a_ram_din[c*8 +: 8];
      if (b_ram_we[c]) b_wr_word[c*8 +: 8] = b_ram_din[c*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (|a_ram_we) mem_a[a_ram_addr] <= a_wr_word;
    a_rd1      <= a_wr_word;
    a_ram_dout <= a_rd1;
    if (|b_ram_we) mem_b[b_ram_addr] <= b_wr_word;
    b_ram_dout <= b_wr_word;
  end

  // reference model for A: word contents plus expected terminations by cycle
  typedef struct { int due; logic ack; logic err; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH_A];
  logic [9:0]  last_addr;

  typedef struct {
    logic        stb; logic we; logic [27:0] adr; logic [31:0] dat; logic [3:0] sel;
    logic        err; logic [31:0] rdata;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // one clock; then compare A's terminations against the model
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc_n++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
      e = exp_q.pop_front();
      check("ack", 32'(a_ack), 32'(e.ack));
      check("err", 32'(a_err), 32'(e.err));
      check("rdata", a_dat_r, e.data);
    end else begin
      check("no_ack", 32'(a_ack), 32'd0);
      check("no_err", 32'(a_err), 32'd0);
    end
  endtask

  // present one bus cycle to A; the model predicts response and RAM strobes
  task automatic drive_a(input logic cyc, input logic stb, input logic we,
                         input logic [27:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic use_tbl,
                         input logic t_err, input logic [31:0] t_data);
    exp_t       e;
    logic       in_rng;
    logic [3:0] exp_we;
    a_cyc = cyc; a_stb = stb; a_we = we; a_adr = adr; a_dat_w = dat; a_sel = sel;
    in_rng = (adr < 28'(DEPTH_A));
    if (!cyc) begin
      exp_q.delete();
    end else if (stb) begin
      e.due  = cyc_n + RL_A + 1;
      e.ack  = in_rng;
      e.err  = !in_rng;
      e.data = 32'd0;
      if (in_rng && we) begin
        for (int c = 0; c < 4; c++)
          if (sel[c]) ref_mem[adr[9:0]][c*8 +: 8] = dat[c*8 +: 8];
      end else if (in_rng) begin
        e.data = ref_mem[adr[9:0]];
      end
      if (use_tbl) begin
        e.err  = t_err;
        e.ack  = !t_err;
        e.data = t_data;
      end
      exp_q.push_back(e);
    end
    #1;
    exp_we = (cyc && stb && we && in_rng) ? sel : 4'd0;
    check("ram_we", 32'(a_ram_we), 32'(exp_we));
    if (cyc && stb) begin
      check("stall_run", 32'(a_stall), 32'd0);
      check("ram_addr", 32'(a_ram_addr), 32'(adr[9:0]));
      last_addr = adr[9:0];
    end else begin
      check("ram_addr_hold", 32'(a_ram_addr), 32'(last_addr));
    end
  endtask

  initial begin
    int n;
    tbl[0]  = '{1'b1, 1'b0, 28'h3FF,     32'h0,        4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 28'h5,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 28'h5,       32'h000000AA, 4'h1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 28'h5,       32'h0,        4'hF, 1'b0, 32'hDEADBEAA};
    tbl[4]  = '{1'b1, 1'b1, 28'h1,       32'h00000011, 4'hF, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 28'h2,       32'h00000022, 4'hF, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 28'h3,       32'h00000033, 4'hF, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 28'h1,       32'h0,        4'hF, 1'b0, 32'h00000011};
    tbl[8]  = '{1'b1, 1'b0, 28'h2,       32'h0,        4'hF, 1'b0, 32'h00000022};
    tbl[9]  = '{1'b1, 1'b0, 28'h3,       32'h0,        4'hF, 1'b0, 32'h00000033};
    tbl[10] = '{1'b1, 1'b1, 28'h0,       32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 28'h0,       32'h0,        4'h0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 28'h400,     32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 28'h0,       32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
    tbl[14] = '{1'b1, 1'b0, 28'hFFFFFFF, 32'h0,        4'hF, 1'b1, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 28'h405,     32'h12121212, 4'h1, 1'b1, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 28'h5,       32'h0,        4'hF, 1'b0, 32'hDEADBEAA};

    a_rst_n = 1'b0; a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    a_adr = '0; a_dat_w = '0; a_sel = '0;
    b_rst_n = 1'b0; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    b_adr = '0; b_dat_w = '0; b_sel = '0;
    for (int i = 0; i < DEPTH_A; i++) ref_mem[i] = 32'd0;

    // reset values
    step(); step();
    check("rst_ack",   32'(a_ack), 32'd0);
    check("rst_err",   32'(a_err), 32'd0);
    check("rst_dat_r", a_dat_r, 32'd0);
    check("rst_we",    32'(a_ram_we), 32'd0);
    check("rst_addr",  32'(a_ram_addr), 32'd0);
    check("rst_din",   a_ram_din, 32'd0);
    check("rst_stall", 32'(a_stall), 32'd1);
    check("rst_stall_b", 32'(b_stall), 32'd1);

    // zero-fill: stall for exactly RAM_DEPTH cycles, writing address n in cycle n
    a_rst_n = 1'b1;
    n = 0;
    while (a_stall && n < 3000) begin
      if (n == 100) begin
        check("clr_we",   32'(a_ram_we), 32'hF);
        check("clr_addr", 32'(a_ram_addr), 32'd100);
        check("clr_din",  a_ram_din, 32'd0);
      end
      n++;
      step();
    end
    check("clear_cycles", n, 32'(DEPTH_A));
    last_addr = 10'(DEPTH_A - 1);

    // table vectors, issued back to back
    for (int i = 0; i < 17; i++) begin
      drive_a(1'b1, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
              1'b1, tbl[i].err, tbl[i].rdata);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      step();
    end

    // cycle abort: read then drop cyc; nothing may terminate afterwards
    drive_a(1'b1, 1'b1, 1'b0, 28'h5, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b0, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      step();
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [27:0] adr;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      adr = 28'($urandom_range(DEPTH_A, 2 * DEPTH_A));
      else if (r == 1) adr = 28'($urandom);
      else if (r == 2) adr = 28'($urandom_range(0, DEPTH_A - 1));
      else             adr = 28'($urandom_range(0, 15));
      drive_a($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
              1'b0, 1'b0, 32'h0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, 28'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      step();
    end

    // B: reset in the middle of a clear restarts it from address 0
    b_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    b_rst_n = 1'b0;
    step();
    check("b_rst_stall", 32'(b_stall), 32'd1);
    b_rst_n = 1'b1;
    #1;
    check("b_restart_addr", 32'(b_ram_addr), 32'd0);
    n = 0;
    while (b_stall && n < 200) begin
      n++;
      step();
    end
    check("b_clear_cycles", n, 32'(DEPTH_B));

    // B: write then read next cycle, low latency termination at accept+2
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 28'h7; b_dat_w = 32'h12345678; b_sel = 4'hF;
    step();
    check("b_ack_early", 32'(b_ack), 32'd0);
    b_we = 1'b0; b_dat_w = 32'h0;
    step();
    check("b_wr_ack", 32'(b_ack), 32'd1);
    check("b_wr_data", b_dat_r, 32'd0);
    b_stb = 1'b0;
    step();
    check("b_rd_ack", 32'(b_ack), 32'd1);
    check("b_rd_err", 32'(b_err), 32'd0);
    check("b_rd_data", b_dat_r, 32'h12345678);
    step();
    check("b_ack_done", 32'(b_ack), 32'd0);
    b_cyc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
